// File: rtl/div_unit.sv
// Iterative 32-bit divider: restoring radix-2, one quotient bit per cycle.
// Supports DIV (two's complement) and DIVU; result packed as {remainder, quotient}.
`timescale 1ns/1ps
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BY_ZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   acc;
  logic [DATA_W-1:0]   dvsr;
  logic                neg_quo;
  logic                neg_rem;

  logic                start_ok;
  logic                dvd_neg;
  logic                dvs_neg;
  logic                step_ge;
  logic [DATA_W-1:0]   step_diff;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    if (sgn && s < 0) mag = $unsigned(-s);
    else              mag = v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    if (neg) apply_sign = $unsigned(-s);
    else     apply_sign = v;
  endfunction

  assign start_ok = start_i & ~annul_i;
  assign dvd_neg  = signed_div_i & opdata1_i[DATA_W-1];
  assign dvs_neg  = signed_div_i & opdata2_i[DATA_W-1];

  // acc[64:32] is the pre-shifted partial remainder; when the trial difference is
  // non-negative it is below the divisor, so 32 bits of it are enough to keep.
  assign step_ge   = acc[2*DATA_W:DATA_W] >= {1'b0, dvsr};
  assign step_diff = acc[2*DATA_W-1:DATA_W] - dvsr;

  // Operand / partial-remainder datapath (no reset: only meaningful while ON)
  always_ff @(posedge clk) begin
    if (state == IDLE && start_ok && opdata2_i != '0) begin
      acc     <= {{DATA_W{1'b0}}, mag(opdata1_i, signed_div_i), 1'b0};
      dvsr    <= mag(opdata2_i, signed_div_i);
      neg_quo <= dvd_neg ^ dvs_neg;
      neg_rem <= dvd_neg;
    end else if (state == ON && cnt != 6'd32) begin
      if (step_ge) acc <= {step_diff, acc[DATA_W-1:0], 1'b1};
      else         acc <= {acc[2*DATA_W-1:0], 1'b0};
    end
  end

  // Control and output registers. The divide-by-zero path enters END with
  // ready still low and raises it on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          cnt      <= 6'd0;
          if (start_ok) begin
            if (opdata2_i == '0) state <= BY_ZERO;
            else                 state <= ON;
          end
        end
        BY_ZERO: begin
          result_o <= '0;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt == 6'd32) begin
            result_o <= {apply_sign(acc[2*DATA_W:DATA_W+1], neg_rem),
                         apply_sign(acc[DATA_W-1:0], neg_quo)};
            ready_o  <= 1'b1;
            cnt      <= 6'd0;
            state    <= END;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        END: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, annul and reset.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Start is already presented; the next rising edge is the sampling edge N.
  task automatic finish(input string tag, input int lat, input logic [63:0] exp);
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~signed_div_i;
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, {63'd0, ready_o}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    chk({tag, "_result"}, result_o, exp);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, {ready_o, result_o[62:0]}, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b0;

    launch(1'b0, 32'd100, 32'd7);
    finish("divu_100_7", 33, {32'd2, 32'd14});
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    finish("div_m7_2", 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    launch(1'b1, 32'd7, 32'd0);
    finish("div_by_zero", 2, 64'd0);
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    finish("div_ovf", 33, {32'd0, 32'h80000000});
    launch(1'b0, 32'h80000000, 32'hFFFFFFFF);
    finish("divu_big", 33, {32'h80000000, 32'd0});
    launch(1'b1, 32'd7, 32'hFFFFFFFE);
    finish("div_7_m2", 33, {32'd1, 32'hFFFFFFFD});
    launch(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    finish("div_m100_m7", 33, {32'hFFFFFFFE, 32'd14});
    launch(1'b0, 32'd5, 32'd7);
    finish("divu_5_7", 33, {32'd5, 32'd0});

    // Annul at iteration 10: no result must ever appear
    launch(1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    chk("annul_idle", {ready_o, result_o[62:0]}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    chk("annul_noready", 64'(seen), 64'd0);
    launch(1'b0, 32'd9, 32'd3);
    finish("divu_9_3", 33, {32'd0, 32'd3});

    // Asynchronous reset at iteration 20, then restart on the first free edge
    launch(1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd1;
    start_i      = 1'b1;
    finish("rst_restart", 33, {32'd0, 32'hFFFFFFFF});

    // Asynchronous reset while a result is being presented
    launch(1'b0, 32'd5, 32'd7);
    @(posedge clk);
    repeat (33) @(posedge clk);
    #2;
    chk("end_before_rst", {ready_o, result_o[62:0]}, {1'b1, 31'd5, 32'd0});
    rst = 1'b1;
    #1;
    chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
